dmem_arbiter: RTL and testbench

//   Two-port sequencer/arbiter in front of the shared data memory (data_mem).

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of the shared data memory; one memory access per grant.
// Latency: request seen in IDLE cycle t, memory strobe in t+1, ack pulse in t+2 (1 access per 3 cycles).
// Backpressure: a requester holds its payload until ack; requests arriving while busy wait and are never dropped.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   last_b;
    logic   grant_b;
    logic   we_q;
    logic   err_q;

    logic              pick_b;
    logic              sel_we;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_val;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        pick_b    = 1'b0;
        if (a_req && b_req) begin
            pick_b = !last_b;
        end else begin
            pick_b = b_req;
        end
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_err   = (sel_addr >= ADDR_LIMIT);
        rd_val    = (we_q || err_q) ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            grant_b   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            a_ack     <= 1'b0;
            a_rdata   <= '0;
            a_err     <= 1'b0;
            b_ack     <= 1'b0;
            b_rdata   <= '0;
            b_err     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant_b   <= pick_b;
                        last_b    <= pick_b;
                        we_q      <= sel_we;
                        err_q     <= sel_err;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_read  <= !sel_we && !sel_err;
                        mem_write <= sel_we && !sel_err;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_addr/mem_wdata keep their value so the memory sees no toggling.
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (grant_b) begin
                        b_ack   <= 1'b1;
                        b_err   <= err_q;
                        b_rdata <= rd_val;
                    end else begin
                        a_ack   <= 1'b1;
                        a_err   <= err_q;
                        a_rdata <= rd_val;
                    end
                    state <= DONE;
                end
                DONE: begin
                    a_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_ack <= 1'b0;
                    b_err <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed reset-mid-write case, then randomized two-port traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    logic [31:0] dmem    [1024];
    logic [31:0] ref_mem [1024];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state: one transaction in flight at most
    int          acc_cyc, ack_cyc, free_cyc, load;
    logic        last_b, m_port, m_we, m_err, acc, ackc;
    logic [31:0] m_addr, m_wdata, m_res, exp_ra, exp_rb, exp_maddr, exp_mwdata;

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? dmem[mem_addr[9:0]] : 32'h0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":a_ack"}, a_ack, 0);
        check({tag, ":b_ack"}, b_ack, 0);
        check({tag, ":a_err"}, a_err, 0);
        check({tag, ":b_err"}, b_err, 0);
        check({tag, ":a_rdata"}, a_rdata, 0);
        check({tag, ":b_rdata"}, b_rdata, 0);
        check({tag, ":mem_addr"}, mem_addr, 0);
        check({tag, ":mem_wdata"}, mem_wdata, 0);
        check({tag, ":mem_read"}, mem_read, 0);
        check({tag, ":mem_write"}, mem_write, 0);
        check({tag, ":busy"}, busy, 0);
    endtask

    task automatic gen(output logic we, output logic [31:0] addr, output logic [31:0] wdata);
        int r;
        r     = $urandom_range(0, 9);
        we    = 1'($urandom_range(0, 1));
        wdata = $urandom;
        case (r)
            0:       addr = 32'd1023;
            1:       addr = 32'd1024;
            2:       addr = $urandom | 32'h400;
            3:       addr = 32'h0001_0000 | $urandom_range(0, 15);
            default: addr = $urandom_range(0, 15);
        endcase
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = i;
            ref_mem[i] = i;
        end
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // write accepted, then reset asserted in the middle of its ACCESS cycle
        rst_n   = 1'b1;
        a_req   = 1'b1;
        a_we    = 1'b1;
        a_addr  = 32'd3;
        a_wdata = 32'h1234_5678;
        @(negedge clk);
        check("pre_rst_mem_write", mem_write, 1);
        check("pre_rst_mem_addr", mem_addr, 3);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        a_req = 1'b0;
        a_we  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_a_ack", a_ack, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_mem_write", mem_write, 0);
        end

        acc_cyc = -1; ack_cyc = -1; free_cyc = 0;
        last_b = 1'b1; m_port = 0; m_we = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_res = 0;
        exp_ra = 0; exp_rb = 0; exp_maddr = 0; exp_mwdata = 0;

        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            acc  = (cyc == acc_cyc);
            ackc = (cyc == ack_cyc);
            if (acc) begin
                exp_maddr  = m_addr;
                exp_mwdata = m_wdata;
            end
            if (ackc && !m_port) exp_ra = m_res;
            if (ackc && m_port)  exp_rb = m_res;

            check("a_ack", a_ack, ackc && !m_port);
            check("b_ack", b_ack, ackc && m_port);
            check("a_err", a_err, ackc && !m_port && m_err);
            check("b_err", b_err, ackc && m_port && m_err);
            check("a_rdata", a_rdata, exp_ra);
            check("b_rdata", b_rdata, exp_rb);
            check("mem_read", mem_read, acc && !m_we && !m_err);
            check("mem_write", mem_write, acc && m_we && !m_err);
            check("mem_addr", mem_addr, exp_maddr);
            check("mem_wdata", mem_wdata, exp_mwdata);
            check("busy", busy, acc || ackc);

            if (mem_write && mem_addr < 32'd1024) dmem[mem_addr[9:0]] = mem_wdata;

            // saturated load first (strict alternation), then lighter mixes
            load = (cyc < 600) ? 100 : ((cyc < 2500) ? 30 : 70);
            if (!a_req || (ackc && !m_port)) begin
                if ($urandom_range(1, 100) <= load) begin
                    a_req = 1'b1;
                    gen(a_we, a_addr, a_wdata);
                end else begin
                    a_req = 1'b0;
                end
            end
            if (!b_req || (ackc && m_port)) begin
                if ($urandom_range(1, 100) <= load) begin
                    b_req = 1'b1;
                    gen(b_we, b_addr, b_wdata);
                end else begin
                    b_req = 1'b0;
                end
            end

            if (cyc >= free_cyc && (a_req || b_req)) begin
                if (a_req && b_req) m_port = ~last_b;
                else                m_port = b_req;
                last_b  = m_port;
                m_we    = m_port ? b_we    : a_we;
                m_addr  = m_port ? b_addr  : a_addr;
                m_wdata = m_port ? b_wdata : a_wdata;
                m_err   = (m_addr >= 32'd1024);
                m_res   = (m_we || m_err) ? 32'h0 : ref_mem[m_addr[9:0]];
                if (m_we && !m_err) ref_mem[m_addr[9:0]] = m_wdata;
                acc_cyc  = cyc + 1;
                ack_cyc  = cyc + 2;
                free_cyc = cyc + 3;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
